// File: rtl/rcb_pkg.sv
// ============================================================================
// Module      : rcb_pkg
// Description : Shared types and constants for the RCB write-side stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rcb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RECOVER  = 3'd4
  } rcb_wr_state_e;

  localparam int c_rd_latency_min = 1;
  localparam int c_rd_latency_max = 4;
  localparam int c_lat_cnt_width  = $clog2(c_rd_latency_max);

  localparam int c_rcb_ram_width  = 64;
  localparam int c_rcb_byte_lanes = c_rcb_ram_width / 8;

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rcb_byte_merge.sv
// ============================================================================
// Module      : rcb_byte_merge
// Description : Per-byte select between new write data and the old RAM word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcb_byte_merge
  import rcb_pkg::*;
#(
  parameter int LANES = c_rcb_byte_lanes
) (
  input  logic [LANES*8-1:0] new_data,
  input  logic [LANES*8-1:0] old_data,
  input  logic [LANES-1:0]   byte_en,
  output logic [LANES*8-1:0] merged
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[i*8 +: 8] = byte_en[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/rcb_hpb_writer.sv
// ============================================================================
// Module      : rcb_hpb_writer
// Description : Commits host bus writes to the RCB RAM, doing read-modify-write
//               for partial byte enables; lookup reads own the read port first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcb_hpb_writer
  import rcb_pkg::*;
#(
  parameter int RCB_RAM_ADDR_WIDTH = 14,
  parameter int RCB_RAM_WIDTH      = 64,
  parameter int RD_LATENCY         = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [RCB_RAM_ADDR_WIDTH-1:0] hpb_wr_addr,
  input  logic [RCB_RAM_WIDTH-1:0]      hpb_wr_data,
  input  logic [RCB_RAM_WIDTH/8-1:0]    hpb_wr_byte_en,
  input  logic                          hpb_wr_req,
  output logic                          rcb_wr_done,
  input  logic                          lkp_rd_en,
  input  logic [RCB_RAM_ADDR_WIDTH-1:0] lkp_rd_addr,
  output logic [RCB_RAM_WIDTH-1:0]      lkp_rd_data,
  output logic                          lkp_rd_valid,
  output logic                          ram_rd_en,
  output logic [RCB_RAM_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [RCB_RAM_WIDTH-1:0]      ram_rd_data,
  output logic                          ram_wr_en,
  output logic [RCB_RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [RCB_RAM_WIDTH-1:0]      ram_wr_data,
  output logic [31:0]                   stat_wr_count,
  output logic [15:0]                   stat_stall_count
);

  localparam int LANES = byte_lanes(RCB_RAM_WIDTH);
  localparam logic [c_lat_cnt_width-1:0] c_lat_last = c_lat_cnt_width'(RD_LATENCY - 1);
  localparam logic [c_lat_cnt_width-1:0] c_lat_one  = c_lat_cnt_width'(1);

  rcb_wr_state_e r_state, w_next;

  logic [RCB_RAM_ADDR_WIDTH-1:0] r_addr;
  logic [RCB_RAM_WIDTH-1:0]      r_data;
  logic [LANES-1:0]              r_be;
  logic [RCB_RAM_WIDTH-1:0]      r_merged;
  logic [RCB_RAM_WIDTH-1:0]      w_merged;
  logic [c_lat_cnt_width-1:0]    r_lat_cnt;
  logic [31:0]                   r_wr_count;
  logic [15:0]                   r_stall_count;

  logic w_accept, w_rmw_rd, w_stall, w_merge_load, w_done;

  rcb_byte_merge #(
    .LANES (LANES)
  ) u_merge (
    .new_data (r_data),
    .old_data (ram_rd_data),
    .byte_en  (r_be),
    .merged   (w_merged)
  );

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_rmw_rd     = 1'b0;
    w_stall      = 1'b0;
    w_merge_load = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (hpb_wr_req) begin
          w_accept = 1'b1;
          // Full-word and empty writes need no old data.
          w_next   = (&hpb_wr_byte_en || ~|hpb_wr_byte_en) ? ST_WRITE : ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        if (lkp_rd_en) begin
          w_stall = 1'b1;
        end else begin
          w_rmw_rd = 1'b1;
          w_next   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (r_lat_cnt == c_lat_last) begin
          w_merge_load = 1'b1;
          w_next       = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_done = 1'b1;
        w_next = ST_RECOVER;
      end
      ST_RECOVER: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_data        <= '0;
      r_be          <= '0;
      r_merged      <= '0;
      r_lat_cnt     <= '0;
      r_wr_count    <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= hpb_wr_addr;
        r_data <= hpb_wr_data;
        r_be   <= hpb_wr_byte_en;
      end
      if (w_rmw_rd) begin
        r_lat_cnt <= '0;
      end else if (r_state == ST_RD_WAIT) begin
        r_lat_cnt <= r_lat_cnt + c_lat_one;
      end
      if (w_merge_load) begin
        r_merged <= w_merged;
      end
      if (w_done) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
      if (w_stall && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  // Lookup always wins the read port; the RMW read only issues when it is free.
  assign ram_rd_en   = lkp_rd_en | w_rmw_rd;
  assign ram_rd_addr = lkp_rd_en ? lkp_rd_addr : (w_rmw_rd ? r_addr : '0);
  assign ram_wr_en   = w_done & (|r_be);
  assign ram_wr_addr = ram_wr_en ? r_addr : '0;
  assign ram_wr_data = ram_wr_en ? ((&r_be) ? r_data : r_merged) : '0;

  assign rcb_wr_done      = w_done;
  assign lkp_rd_data      = ram_rd_data;
  assign stat_wr_count    = r_wr_count;
  assign stat_stall_count = r_stall_count;

  if (RD_LATENCY == 1) begin : g_lkp_pipe_one
    logic r_lkp_valid;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_lkp_valid <= 1'b0;
      else          r_lkp_valid <= lkp_rd_en;
    end
    assign lkp_rd_valid = r_lkp_valid;
  end else begin : g_lkp_pipe_multi
    logic [RD_LATENCY-1:0] r_lkp_pipe;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_lkp_pipe <= '0;
      else          r_lkp_pipe <= {r_lkp_pipe[RD_LATENCY-2:0], lkp_rd_en};
    end
    assign lkp_rd_valid = r_lkp_pipe[RD_LATENCY-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_rcb_hpb_writer.sv
// ============================================================================
// Module      : tb_rcb_hpb_writer
// Description : Directed vector bench for rcb_hpb_writer with a latency-2 RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rcb_hpb_writer;

  localparam int AW  = 14;
  localparam int DW  = 64;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] hpb_wr_addr = '0;
  logic [DW-1:0] hpb_wr_data = '0;
  logic [BW-1:0] hpb_wr_byte_en = '0;
  logic          hpb_wr_req = 1'b0;
  logic          rcb_wr_done;
  logic          lkp_rd_en = 1'b0;
  logic [AW-1:0] lkp_rd_addr = '0;
  logic [DW-1:0] lkp_rd_data;
  logic          lkp_rd_valid;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [31:0]   stat_wr_count;
  logic [15:0]   stat_stall_count;

  always #5 clk = ~clk;

  rcb_hpb_writer #(
    .RCB_RAM_ADDR_WIDTH (AW),
    .RCB_RAM_WIDTH      (DW),
    .RD_LATENCY         (LAT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .hpb_wr_addr      (hpb_wr_addr),
    .hpb_wr_data      (hpb_wr_data),
    .hpb_wr_byte_en   (hpb_wr_byte_en),
    .hpb_wr_req       (hpb_wr_req),
    .rcb_wr_done      (rcb_wr_done),
    .lkp_rd_en        (lkp_rd_en),
    .lkp_rd_addr      (lkp_rd_addr),
    .lkp_rd_data      (lkp_rd_data),
    .lkp_rd_valid     (lkp_rd_valid),
    .ram_rd_en        (ram_rd_en),
    .ram_rd_addr      (ram_rd_addr),
    .ram_rd_data      (ram_rd_data),
    .ram_wr_en        (ram_wr_en),
    .ram_wr_addr      (ram_wr_addr),
    .ram_wr_data      (ram_wr_data),
    .stat_wr_count    (stat_wr_count),
    .stat_stall_count (stat_stall_count)
  );

  // RAM model: read data appears LAT cycles after the address is presented.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_addr_q [LAT];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)     mem[pl_addr]     <= pl_data;
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_addr_q[0] <= ram_rd_addr;
    for (int i = 1; i < LAT; i++) rd_addr_q[i] <= rd_addr_q[i-1];
  end
  assign ram_rd_data = mem[rd_addr_q[LAT-1]];

  int n_cmp = 0;
  int n_err = 0;
  int exp_wr_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [DW-1:0] pre;
    int            lat;
    int            n_rd;
    logic          wr_en;
    logic [DW-1:0] wr_data;
  } vec_t;

  vec_t vecs[6];

  // One host write; hold keeps req high through the cycle after done.
  task automatic run_write(input vec_t v, input bit hold);
    int done_k = -1;
    int rd_cnt = 0;
    logic [AW-1:0] rd_a = '0;
    logic got_en = 1'b0;
    logic [AW-1:0] got_a = '0;
    logic [DW-1:0] got_d = '0;
    preload(v.addr, v.pre);
    @(posedge clk); #1;
    hpb_wr_req = 1'b1; hpb_wr_addr = v.addr; hpb_wr_data = v.data; hpb_wr_byte_en = v.be;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_rd_en) begin rd_cnt++; rd_a = ram_rd_addr; end
      if (rcb_wr_done) begin
        done_k = k; got_en = ram_wr_en; got_a = ram_wr_addr; got_d = ram_wr_data;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_k >= 0) exp_wr_count++;
    check("done_latency", 64'(done_k), 64'(v.lat));
    check("ram_rd_count", 64'(rd_cnt), 64'(v.n_rd));
    if (v.n_rd != 0) check("rmw_rd_addr", 64'(rd_a), 64'(v.addr));
    check("ram_wr_en", 64'(got_en), 64'(v.wr_en));
    if (v.wr_en) begin
      check("ram_wr_addr", 64'(got_a), 64'(v.addr));
      check("ram_wr_data", got_d, v.wr_data);
    end
    @(posedge clk); #1;
    if (!hold) hpb_wr_req = 1'b0;
    @(negedge clk);
    check("done_single_pulse", 64'(rcb_wr_done), 64'd0);
    if (hold) begin
      @(posedge clk); #1;
      hpb_wr_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("held_req_no_reaccept", 64'(rcb_wr_done), 64'd0);
      end
    end
    check("ram_contents", mem[v.addr], v.wr_en ? v.wr_data : v.pre);
    check("stat_wr_count", 64'(stat_wr_count), 64'(exp_wr_count));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_done"},       64'(rcb_wr_done), 64'd0);
    check({tag, "_ram_wr_en"},  64'(ram_wr_en), 64'd0);
    check({tag, "_ram_wr_data"}, ram_wr_data, 64'd0);
    check({tag, "_ram_rd_en"},  64'(ram_rd_en), 64'd0);
    check({tag, "_lkp_valid"},  64'(lkp_rd_valid), 64'd0);
    check({tag, "_wr_count"},   64'(stat_wr_count), 64'd0);
    check({tag, "_stall_count"}, 64'(stat_stall_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t hv;
    vecs[0] = '{addr:14'h0010, data:64'h1122334455667788, be:8'hFF, pre:64'h0,
                lat:1, n_rd:0, wr_en:1'b1, wr_data:64'h1122334455667788};
    vecs[1] = '{addr:14'h0020, data:64'h1122334455667788, be:8'h0F, pre:64'hAAAAAAAAAAAAAAAA,
                lat:4, n_rd:1, wr_en:1'b1, wr_data:64'hAAAAAAAA55667788};
    vecs[2] = '{addr:14'h0030, data:64'h1122334455667788, be:8'h00, pre:64'h5555555555555555,
                lat:1, n_rd:0, wr_en:1'b0, wr_data:64'h0};
    vecs[3] = '{addr:14'h0040, data:64'h1122334455667788, be:8'hF0, pre:64'h0123456789ABCDEF,
                lat:4, n_rd:1, wr_en:1'b1, wr_data:64'h1122334489ABCDEF};
    vecs[4] = '{addr:14'h3FFF, data:64'hFFEEDDCCBBAA9988, be:8'h81, pre:64'h0,
                lat:4, n_rd:1, wr_en:1'b1, wr_data:64'hFF00000000000088};
    vecs[5] = '{addr:14'h0001, data:64'hDEADBEEFCAFEF00D, be:8'h01, pre:64'h1111111111111111,
                lat:4, n_rd:1, wr_en:1'b1, wr_data:64'h111111111111110D};
    for (int i = 0; i < LAT; i++) rd_addr_q[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_write(vecs[i], 1'b0);
    check("stall_after_table", 64'(stat_stall_count), 64'd0);

    // Contention: lookups in T+1..T+3 push the RMW read to T+4, done at T+7.
    preload(14'h0020, 64'hAAAAAAAAAAAAAAAA);
    for (int j = 1; j <= 3; j++) preload(AW'(32'h100 + j), 64'(j) * 64'h0101010101010101);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        hpb_wr_req = 1'b1; hpb_wr_addr = 14'h0020;
        hpb_wr_data = 64'h1122334455667788; hpb_wr_byte_en = 8'h0F;
      end
      if (k == 8) hpb_wr_req = 1'b0;
      lkp_rd_en   = (k >= 1 && k <= 3);
      lkp_rd_addr = AW'(32'h100 + k);
      @(negedge clk);
      if (k >= 1 && k <= 3) begin
        check("cont_lkp_rd_en", 64'(ram_rd_en), 64'd1);
        check("cont_lkp_rd_addr", 64'(ram_rd_addr), 64'(32'h100 + k));
      end
      if (k == 4) begin
        check("cont_rmw_rd_en", 64'(ram_rd_en), 64'd1);
        check("cont_rmw_rd_addr", 64'(ram_rd_addr), 64'h20);
      end
      check("cont_lkp_valid", 64'(lkp_rd_valid), 64'(k >= 3 && k <= 5));
      if (k >= 3 && k <= 5)
        check("cont_lkp_data", lkp_rd_data, 64'(k - 2) * 64'h0101010101010101);
      check("cont_done", 64'(rcb_wr_done), 64'(k == 7));
      if (k == 7) check("cont_wr_data", ram_wr_data, 64'hAAAAAAAA55667788);
    end
    lkp_rd_en = 1'b0;
    exp_wr_count++;
    check("cont_stall_count", 64'(stat_stall_count), 64'd3);
    check("cont_wr_count", 64'(stat_wr_count), 64'(exp_wr_count));

    // Held request is not re-accepted; a fresh request then completes normally.
    hv = '{addr:14'h0050, data:64'h0F0E0D0C0B0A0908, be:8'hFF, pre:64'h0,
           lat:1, n_rd:0, wr_en:1'b1, wr_data:64'h0F0E0D0C0B0A0908};
    run_write(hv, 1'b1);
    run_write(vecs[3], 1'b0);

    // Reset while the RMW read is outstanding.
    preload(14'h0060, 64'hCAFECAFECAFECAFE);
    @(posedge clk); #1;
    hpb_wr_req = 1'b1; hpb_wr_addr = 14'h0060;
    hpb_wr_data = 64'h0123456789ABCDEF; hpb_wr_byte_en = 8'h3C;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("midreset");
    hpb_wr_req = 1'b0;
    exp_wr_count = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midreset_no_write", 64'(ram_wr_en | rcb_wr_done), 64'd0);
    end
    check("midreset_ram_kept", mem[14'h0060], 64'hCAFECAFECAFECAFE);
    run_write(vecs[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
